// File: rtl/word_scanner.sv
// Scans the stored secret word against one guessed letter and reveals matches.
// Tracks the revealed mask, remaining-letter count and per-scan match summary.
module word_scanner #(
    parameter int ADDR_W = 5,
    parameter int CHAR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    input  logic [CHAR_W-1:0] i_guess,
    input  logic              i_new_word,
    input  logic [ADDR_W-1:0] i_word_len,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [CHAR_W-1:0] i_ram_q,
    output logic              o_busy,
    output logic              o_pos_valid,
    output logic [ADDR_W-1:0] o_pos,
    output logic              o_done,
    output logic              o_match,
    output logic [ADDR_W-1:0] o_match_count,
    output logic [ADDR_W-1:0] o_remaining,
    output logic              o_all_found
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [ADDR_W-1:0]      r_addr;
    logic [ADDR_W-1:0]      r_prev;
    logic [ADDR_W-1:0]      r_len;
    logic [ADDR_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]      r_rem;
    logic [CHAR_W-1:0]      r_guess;
    logic [2**ADDR_W-1:0]   r_rev;
    logic                   r_cmp_v;
    logic                   r_loaded;
    logic                   r_match;

    logic w_accept;
    logic w_hit;
    logic w_busy;
    logic w_done;

    assign w_accept = (r_state == S_IDLE) && i_start;

    // RAM data arriving now belongs to the address issued last cycle
    assign w_hit = r_cmp_v
                && (i_ram_q == r_guess)
                && (r_guess != '0)
                && !r_rev[r_prev];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start)
                    w_next = (i_word_len == '0) ? S_DONE : S_SCAN;
            end
            S_SCAN: begin
                w_busy = 1'b1;
                if (r_addr == r_len) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_addr   <= '0;
            r_prev   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_guess  <= '0;
            r_rev    <= '0;
            r_cmp_v  <= 1'b0;
            r_loaded <= 1'b0;
            r_match  <= 1'b0;
        end else begin
            r_cmp_v <= (r_state == S_SCAN);
            r_prev  <= r_addr;
            if ((r_state == S_IDLE) && i_new_word) begin
                r_rev    <= '0;
                r_rem    <= i_word_len;
                r_loaded <= 1'b1;
            end
            if (w_accept) begin
                r_guess <= i_guess;
                r_len   <= i_word_len;
                r_cnt   <= '0;
                r_match <= 1'b0;
                r_addr  <= (i_word_len == '0) ? '0 : ADDR_W'(1);
            end
            if ((r_state == S_SCAN) && (r_addr != r_len))
                r_addr <= r_addr + ADDR_W'(1);
            // Last compare happens in DRAIN, so fold its hit into match here
            if (r_state == S_DRAIN) begin
                r_addr  <= '0;
                r_match <= (r_cnt != '0) || w_hit;
            end
            if (w_hit) begin
                r_rev[r_prev] <= 1'b1;
                r_cnt         <= r_cnt + ADDR_W'(1);
                if (r_rem != '0) r_rem <= r_rem - ADDR_W'(1);
            end
        end
    end

    assign o_ram_addr    = r_addr;
    assign o_busy        = w_busy;
    assign o_pos_valid   = w_hit;
    assign o_pos         = r_prev;
    assign o_done        = w_done;
    assign o_match       = r_match;
    assign o_match_count = r_cnt;
    assign o_remaining   = r_rem;
    assign o_all_found   = r_loaded && (r_rem == '0);

endmodule

// File: tb/tb_word_scanner.sv
// Randomized bench for word_scanner against a set/count reference model.
// Checks strobes per cycle, done latency and end-of-scan summary values.
module tb_word_scanner;

    logic       clk;
    logic       resetn;
    logic       i_start;
    logic [4:0] i_guess;
    logic       i_new_word;
    logic [4:0] i_word_len;
    logic [4:0] o_ram_addr;
    logic [4:0] ram_q;
    logic       o_busy;
    logic       o_pos_valid;
    logic [4:0] o_pos;
    logic       o_done;
    logic       o_match;
    logic [4:0] o_match_count;
    logic [4:0] o_remaining;
    logic       o_all_found;

    word_scanner #(.ADDR_W(5), .CHAR_W(5)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_start       (i_start),
        .i_guess       (i_guess),
        .i_new_word    (i_new_word),
        .i_word_len    (i_word_len),
        .o_ram_addr    (o_ram_addr),
        .i_ram_q       (ram_q),
        .o_busy        (o_busy),
        .o_pos_valid   (o_pos_valid),
        .o_pos         (o_pos),
        .o_done        (o_done),
        .o_match       (o_match),
        .o_match_count (o_match_count),
        .o_remaining   (o_remaining),
        .o_all_found   (o_all_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] mem [32];
    always @(posedge clk) ram_q <= mem[o_ram_addr];

    int n_chk = 0;
    int n_bad = 0;

    bit m_rev [32];
    int m_rem;
    bit m_loaded;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int a = 0; a < 32; a++) m_rev[a] = 1'b0;
    endtask

    task automatic run_scan(input int g, input int len, input bit nw,
                            input bit poke);
        bit eh [32];
        int hits;
        int c;
        int exp_done;
        bit seen;
        bit exp_pv;
        @(posedge clk); #1;
        i_start    = 1'b1;
        i_new_word = nw;
        i_guess    = g[4:0];
        i_word_len = len[4:0];
        if (nw) begin
            clear_model();
            m_rem    = len;
            m_loaded = 1'b1;
        end
        hits = 0;
        for (int a = 0; a < 32; a++) eh[a] = 1'b0;
        for (int a = 1; a <= len; a++) begin
            if (g != 0 && int'(mem[a]) == g && !m_rev[a]) begin
                eh[a]    = 1'b1;
                m_rev[a] = 1'b1;
                hits++;
                if (m_rem > 0) m_rem--;
            end
        end
        exp_done = (len == 0) ? 1 : len + 2;
        @(posedge clk); #1;
        i_start    = 1'b0;
        i_new_word = 1'b0;
        i_guess    = 5'($urandom);
        i_word_len = 5'($urandom);
        c = 1;
        seen = 1'b0;
        while (!seen && c <= len + 4) begin
            @(negedge clk);
            if (poke) begin
                i_start    = (c == 2);
                i_new_word = (c == 2);
            end
            check("busy", 32'(o_busy), 1);
            if (c <= len) check("ram_addr", 32'(o_ram_addr), 32'(c));
            else if (c == len + 1)
                check("ram_addr_hold", 32'(o_ram_addr), 32'(len));
            exp_pv = (c >= 2) && (c <= len + 1) && eh[c-1];
            check("pos_valid", 32'(o_pos_valid), 32'(exp_pv));
            if (o_pos_valid && exp_pv) check("pos", 32'(o_pos), 32'(c - 1));
            if (o_done) begin
                seen = 1'b1;
                check("done_cycle", 32'(c), 32'(exp_done));
                check("match", 32'(o_match), 32'(hits != 0));
                check("match_count", 32'(o_match_count), 32'(hits));
                check("remaining", 32'(o_remaining), 32'(m_rem));
                check("all_found", 32'(o_all_found),
                      32'(m_loaded && m_rem == 0));
            end else begin
                c++;
            end
        end
        i_start    = 1'b0;
        i_new_word = 1'b0;
        if (!seen) check("done_timeout", 0, 1);
        @(negedge clk);
        check("idle_after_done", 32'(o_busy), 0);
    endtask

    initial begin
        int cur_len;
        resetn     = 1'b1;
        i_start    = 1'b0;
        i_new_word = 1'b0;
        i_guess    = '0;
        i_word_len = '0;
        for (int a = 0; a < 32; a++) mem[a] = '0;
        clear_model();
        m_rem    = 0;
        m_loaded = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_addr", 32'(o_ram_addr), 0);
        check("rst_remaining", 32'(o_remaining), 0);
        check("rst_all_found", 32'(o_all_found), 0);
        check("rst_match", 32'(o_match), 0);
        resetn = 1'b0;

        mem[1] = 5'd3; mem[2] = 5'd1; mem[3] = 5'd2;
        run_scan(1, 3, 1'b1, 1'b0);
        run_scan(1, 3, 1'b0, 1'b0);
        run_scan(3, 3, 1'b0, 1'b1);

        for (int a = 1; a <= 4; a++) mem[a] = 5'd1;
        run_scan(1, 4, 1'b1, 1'b0);

        run_scan(1, 0, 1'b1, 1'b0);
        check("len0_addr", 32'(o_ram_addr), 0);

        mem[1] = 5'd0; mem[2] = 5'd3; mem[3] = 5'd0;
        mem[4] = 5'd1; mem[5] = 5'd0;
        run_scan(0, 5, 1'b1, 1'b0);
        run_scan(1, 5, 1'b0, 1'b0);
        run_scan(1, 5, 1'b1, 1'b0);

        for (int a = 1; a <= 10; a++) mem[a] = 5'(a % 3 + 1);
        @(posedge clk); #1;
        i_start = 1'b1; i_new_word = 1'b1;
        i_guess = 5'd2; i_word_len = 5'd10;
        @(posedge clk); #1;
        i_start = 1'b0; i_new_word = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        resetn = 1'b1;
        #1;
        check("arst_busy", 32'(o_busy), 0);
        check("arst_pos_valid", 32'(o_pos_valid), 0);
        check("arst_addr", 32'(o_ram_addr), 0);
        check("arst_count", 32'(o_match_count), 0);
        check("arst_remaining", 32'(o_remaining), 0);
        check("arst_all_found", 32'(o_all_found), 0);
        clear_model();
        m_rem    = 0;
        m_loaded = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("arst_no_done", 32'(o_done), 0);
        end
        run_scan(2, 10, 1'b1, 1'b0);

        cur_len = 0;
        for (int it = 0; it < 60; it++) begin
            bit nw;
            nw = (it == 0) || ($urandom_range(0, 3) == 0);
            if (nw) begin
                cur_len = $urandom_range(0, 31);
                for (int a = 1; a < 32; a++)
                    mem[a] = 5'($urandom_range(0, 5));
            end
            run_scan($urandom_range(0, 5), cur_len, nw,
                     $urandom_range(0, 4) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/word_scanner.md
# word_scanner

Reads back the secret word that the game datapath writes into the 32x5 character RAM, and compares every stored letter against one player guess. For each letter position that matches and is not yet revealed, it emits a position strobe to the blank-fill logic. It also tracks the per-word revealed mask and the count of remaining letters. The game controller uses its `match`, `done` and `all_found` outputs to choose between drawing a hangman part, filling blanks and ending the round.

## Interface
Parameters:
- ADDR_W, 5: RAM address width. Word letters occupy addresses 1..2^ADDR_W-1.
- CHAR_W, 5: character code width. Code 0 means blank/invalid; codes 1..26 are A..Z.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-high reset.
- start  in  1  begin a scan using `guess`. Sampled only in IDLE.
- guess  in  CHAR_W  guessed character code, latched on accepted `start`.
- new_word  in  1  clears the revealed mask and loads `remaining` from `word_len`. Sampled only in IDLE.
- word_len  in  ADDR_W  number of stored letters, 0..31.
- ram_addr  out  ADDR_W  read address to the character RAM.
- ram_q  in  CHAR_W  RAM read data, valid one cycle after `ram_addr` is presented.
- busy  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- pos_valid  out  1  one-cycle strobe, once per newly revealed position.
- pos  out  ADDR_W  address of the revealed letter, valid with `pos_valid`.
- done  out  1  one-cycle pulse at the end of a scan.
- match  out  1  set at `done` if at least one position was newly revealed by this scan. Held until the next accepted `start`.
- match_count  out  ADDR_W  number of newly revealed positions in the last scan. Held like `match`.
- remaining  out  ADDR_W  unrevealed letters in the current word.
- all_found  out  1  `remaining` == 0 and a word is loaded.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - `new_word`=1 clears `revealed[31:0]`, loads `remaining` from `word_len` and sets the `loaded` flag.
  - `start`=1 latches `guess` and `word_len` (as L), sets idx=1 and clears `match_count`.
  - On `start`: if L==0, go to DONE. Otherwise go to SCAN.
  - If `new_word` and `start` arrive in the same cycle, `new_word` is applied first; the scan then uses the cleared mask.
- SCAN:
  - `ram_addr`=idx each cycle; idx increments.
  - After idx==L is issued, go to DRAIN.
- Compare stage, one cycle behind the address:
  - Let a = previous `ram_addr`.
  - If `ram_q`==guess, guess!=0 and `revealed[a]`==0: set `revealed[a]`, pulse `pos_valid` with `pos`=a, increment `match_count`, decrement `remaining`.
  - A letter already revealed is neither re-signalled nor counted.
- DRAIN: performs the compare for address L only. No new address is issued; `ram_addr` holds L. Then go to DONE.
- DONE: pulse `done`; `match` = (`match_count`!=0); return to IDLE.
- Arithmetic:
  - `remaining` saturates at 0 and never wraps.
  - `match_count` ≤ L, so it fits ADDR_W bits.
  - idx is ADDR_W bits. L=31 is the maximum, so idx never wraps during a scan.
- Ignored inputs: `start` and `new_word` are ignored outside IDLE. `guess` changes after the start cycle have no effect.
- Reset (any time, including mid-scan): state=IDLE, all outputs 0, `revealed`=0, `loaded`=0, `ram_addr`=0. Any scan in progress is abandoned with no `done`.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycles 1..L: `ram_addr`=1..L; `busy`=1.
- Cycles 2..L+1: compare results; `pos_valid` strobes occur here.
- Cycle L+2: `done`=1; `match`, `match_count`, `remaining` and `all_found` are final from this cycle.
- Total latency from start to done: L+2 cycles.
- L==0: `done` at cycle 1, `match`=0, no RAM reads.
- Next `start` is accepted at cycle L+3 at the earliest.
- `pos_valid` pulses appear in ascending address order, at most one per cycle.
- `all_found` is combinational from `remaining`/`loaded`, so it updates the cycle after the last decrement.

## Test plan
- Word C,A,B (3,1,2) at addresses 1..3; `new_word` with `word_len`=3; `start` with `guess`=1 -> `ram_addr` 1,2,3 on cycles 1..3; `pos_valid` with `pos`=2 on cycle 3; `done` on cycle 5; `match`=1, `match_count`=1, `remaining`=2.
- Same word, `guess`=1 again -> no `pos_valid`; `done` on cycle 5; `match`=0, `remaining`=2 (repeated guess is not re-counted).
- Word A,A,A,A (`word_len`=4), `guess`=1 -> `pos_valid` with `pos`=1..4 on consecutive cycles 2..5; `match_count`=4, `remaining`=0, `all_found`=1 on cycle 6.
- `word_len`=0, `start` -> `done` on cycle 1, `match`=0, `ram_addr` stays 0. Separately, `guess`=0 over a word containing code-0 entries -> `match`=0.
- Assert `resetn` on cycle 3 of a 10-letter scan -> all outputs 0 the same cycle, no `done` follows; a new `new_word`+`start` afterwards completes normally.
- `start` pulsed during SCAN, and `new_word` and `start` in the same IDLE cycle -> the mid-scan `start` is ignored; the same-cycle case clears the mask first, then scans with all positions eligible.
